// File: rtl/fifo_buffer_mc.sv
// rtl/fifo_buffer_mc.sv - multi-channel first-word-fall-through FIFO
// n_ch independent queues share one storage array addressed {channel, index}.
module fifo_buffer_mc #(
    parameter  int data_width = 16,
    parameter  int n          = 16,
    parameter  int n_ch       = 4,
    parameter  int af_level   = 12,
    localparam int cw         = (n_ch > 1) ? $clog2(n_ch) : 1,
    localparam int aw         = $clog2(n)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [cw-1:0]         wr_ch,
    input  logic [data_width-1:0] data_in,
    input  logic                  next,
    input  logic [cw-1:0]         rd_ch,
    output logic [data_width-1:0] data_out,
    input  logic [n_ch-1:0]       flush,
    input  logic                  clear_err,
    output logic [n_ch-1:0]       nonempty,
    output logic [n_ch-1:0]       full,
    output logic [n_ch-1:0]       almost_full,
    output logic [n_ch-1:0]       overflow,
    output logic [n_ch-1:0]       underflow,
    output logic [aw:0]           rd_count
);

    generate
        if (n < 2 || (n & (n - 1)) != 0 || n_ch < 1 || af_level < 1 || af_level > n) begin : g_bad_params
            $error("fifo_buffer_mc: illegal parameter combination");
        end
    endgenerate

    localparam logic [cw:0] ch_lim   = (cw + 1)'(n_ch);
    localparam logic [aw:0] cnt_full = (aw + 1)'(n);
    localparam logic [aw:0] cnt_af   = (aw + 1)'(af_level);

    logic [data_width-1:0] r_mem    [2**(cw+aw)];
    logic [aw-1:0]         r_wr_idx [n_ch];
    logic [aw-1:0]         r_rd_idx [n_ch];
    logic [aw:0]           r_count  [n_ch];
    logic [n_ch-1:0]       r_ovf;
    logic [n_ch-1:0]       r_unf;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [n_ch-1:0]       w_wsel;
    logic [n_ch-1:0]       w_rsel;
    logic [n_ch-1:0]       w_wacc;
    logic [n_ch-1:0]       w_racc;

    // Channel selects beyond n_ch never match any channel, so such requests are ignored.
    always_comb begin
        w_wr_ok     = {1'b0, wr_ch} < ch_lim;
        w_rd_ok     = {1'b0, rd_ch} < ch_lim;
        nonempty    = '0;
        full        = '0;
        almost_full = '0;
        w_wsel      = '0;
        w_rsel      = '0;
        w_wacc      = '0;
        w_racc      = '0;
        for (int c = 0; c < n_ch; c++) begin
            nonempty[c]    = r_count[c] != '0;
            full[c]        = r_count[c] == cnt_full;
            almost_full[c] = r_count[c] >= cnt_af;
            w_wsel[c]      = write && w_wr_ok && (wr_ch == cw'(c));
            w_rsel[c]      = next && w_rd_ok && (rd_ch == cw'(c));
            w_wacc[c]      = w_wsel[c] && !full[c] && !flush[c];
            w_racc[c]      = w_rsel[c] && nonempty[c] && !flush[c];
        end
    end

    always_ff @(posedge clk) begin
        if (|w_wacc) begin
            r_mem[{wr_ch, r_wr_idx[wr_ch]}] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < n_ch; c++) begin
                r_wr_idx[c] <= '0;
                r_rd_idx[c] <= '0;
                r_count[c]  <= '0;
            end
            r_ovf <= '0;
            r_unf <= '0;
        end else begin
            for (int c = 0; c < n_ch; c++) begin
                if (flush[c]) begin
                    r_wr_idx[c] <= '0;
                    r_rd_idx[c] <= '0;
                    r_count[c]  <= '0;
                end else begin
                    if (w_wacc[c]) begin
                        r_wr_idx[c] <= r_wr_idx[c] + 1'b1;
                    end
                    if (w_racc[c]) begin
                        r_rd_idx[c] <= r_rd_idx[c] + 1'b1;
                    end
                    if (w_wacc[c] && !w_racc[c]) begin
                        r_count[c] <= r_count[c] + 1'b1;
                    end else if (w_racc[c] && !w_wacc[c]) begin
                        r_count[c] <= r_count[c] - 1'b1;
                    end
                end
            end
            // A new error event outranks a simultaneous clear.
            r_ovf <= (w_wsel & full & ~flush) | (r_ovf & ~{n_ch{clear_err}});
            r_unf <= (w_rsel & ~nonempty & ~flush) | (r_unf & ~{n_ch{clear_err}});
        end
    end

    always_comb begin
        data_out = '0;
        rd_count = '0;
        if (w_rd_ok) begin
            rd_count = r_count[rd_ch];
            if (r_count[rd_ch] != '0) begin
                data_out = r_mem[{rd_ch, r_rd_idx[rd_ch]}];
            end
        end
    end

    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_fifo_buffer_mc.sv
// tb/tb_fifo_buffer_mc.sv - self-checking bench for fifo_buffer_mc
// Queue-based reference model compared every falling edge, plus literal expectations.
module tb_fifo_buffer_mc;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int NC = 2;
    localparam int AF = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic          wr_ch = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          next = 1'b0;
    logic          rd_ch = 1'b0;
    logic [DW-1:0] data_out;
    logic [NC-1:0] flush = '0;
    logic          clear_err = 1'b0;
    logic [NC-1:0] nonempty;
    logic [NC-1:0] full;
    logic [NC-1:0] almost_full;
    logic [NC-1:0] overflow;
    logic [NC-1:0] underflow;
    logic [2:0]    rd_count;

    int checks = 0;
    int errors = 0;

    fifo_buffer_mc #(
        .data_width (DW),
        .n          (N),
        .n_ch       (NC),
        .af_level   (AF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .wr_ch       (wr_ch),
        .data_in     (data_in),
        .next        (next),
        .rd_ch       (rd_ch),
        .data_out    (data_out),
        .flush       (flush),
        .clear_err   (clear_err),
        .nonempty    (nonempty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .rd_count    (rd_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mq [NC][$];
    logic [NC-1:0] m_ovf = '0;
    logic [NC-1:0] m_unf = '0;
    logic [NC-1:0] m_wok, m_rok, m_so, m_su;
    int            m_sz [NC];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NC; c++) mq[c].delete();
            m_ovf = '0;
            m_unf = '0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                m_sz[c]  = mq[c].size();
                m_wok[c] = write && (int'(wr_ch) == c) && (m_sz[c] < N) && !flush[c];
                m_rok[c] = next && (int'(rd_ch) == c) && (m_sz[c] > 0) && !flush[c];
                m_so[c]  = write && (int'(wr_ch) == c) && (m_sz[c] == N) && !flush[c];
                m_su[c]  = next && (int'(rd_ch) == c) && (m_sz[c] == 0) && !flush[c];
            end
            for (int c = 0; c < NC; c++) begin
                if (flush[c]) begin
                    mq[c].delete();
                end else begin
                    if (m_rok[c]) void'(mq[c].pop_front());
                    if (m_wok[c]) mq[c].push_back(data_in);
                end
            end
            m_ovf = m_so | (m_ovf & ~{NC{clear_err}});
            m_unf = m_su | (m_unf & ~{NC{clear_err}});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [NC-1:0] e_ne, e_full, e_af;
    logic [DW-1:0] e_do;
    int            e_cnt;

    always @(negedge clk) begin
        for (int c = 0; c < NC; c++) begin
            e_ne[c]   = mq[c].size() != 0;
            e_full[c] = mq[c].size() == N;
            e_af[c]   = mq[c].size() >= AF;
        end
        e_cnt = mq[int'(rd_ch)].size();
        e_do  = (e_cnt > 0) ? mq[int'(rd_ch)][0] : '0;
        chk("model_nonempty",    32'(nonempty),    32'(e_ne));
        chk("model_full",        32'(full),        32'(e_full));
        chk("model_almost_full", 32'(almost_full), 32'(e_af));
        chk("model_overflow",    32'(overflow),    32'(m_ovf));
        chk("model_underflow",   32'(underflow),   32'(m_unf));
        chk("model_rd_count",    32'(rd_count),    32'(e_cnt));
        chk("model_data_out",    32'(data_out),    32'(e_do));
    end

    task automatic cyc(input logic w, input logic wc, input logic [DW-1:0] d,
                       input logic nx, input logic rc, input logic [NC-1:0] fl, input logic ce);
        write = w; wr_ch = wc; data_in = d; next = nx; rd_ch = rc; flush = fl; clear_err = ce;
        @(posedge clk);
        #2;
        write = 1'b0; next = 1'b0; flush = '0; clear_err = 1'b0;
    endtask

    task automatic look(input logic rc);
        rd_ch = rc;
        #1;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_nonempty", 32'(nonempty), 0);
        chk("reset_rd_count", 32'(rd_count), 0);
        chk("reset_data_out", 32'(data_out), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // 1: three writes into ch0, then drain
        cyc(1, 0, 8'h11, 0, 0, 2'b00, 0);
        cyc(1, 0, 8'h22, 0, 0, 2'b00, 0);
        cyc(1, 0, 8'h33, 0, 0, 2'b00, 0);
        chk("t1_almost_full", 32'(almost_full[0]), 1);
        chk("t1_head", 32'(data_out), 32'h11);
        chk("t1_rd_count", 32'(rd_count), 3);
        cyc(0, 0, 8'h00, 1, 0, 2'b00, 0);
        chk("t1_pop2_head", 32'(data_out), 32'h22);
        cyc(0, 0, 8'h00, 1, 0, 2'b00, 0);
        chk("t1_pop3_head", 32'(data_out), 32'h33);
        cyc(0, 0, 8'h00, 1, 0, 2'b00, 0);
        chk("t1_nonempty", 32'(nonempty[0]), 0);
        chk("t1_empty_data", 32'(data_out), 0);

        // 2: fill ch1 and overfill
        for (int i = 0; i < 5; i++) cyc(1, 1, 8'hB0 + 8'(i), 0, 1, 2'b00, 0);
        chk("t2_full", 32'(full[1]), 1);
        chk("t2_overflow", 32'(overflow[1]), 1);
        chk("t2_count", 32'(rd_count), 4);
        cyc(0, 0, 8'h00, 0, 1, 2'b00, 1);
        chk("t2_clear_err", 32'(overflow[1]), 0);

        // 3: cross-channel interleave over index wrap-around
        for (int i = 0; i < 6; i++) begin
            look(1);
            chk("t3_ch1_head", 32'(data_out), (i < 4) ? 32'hB0 + 32'(i) : 32'hC0 + 32'(i - 4));
            cyc(1, 0, 8'hA0 + 8'(i), 1, 1, 2'b00, 0);
            look(0);
            chk("t3_ch0_head", 32'(data_out), 32'hA0 + 32'(i));
            cyc(1, 1, 8'hC0 + 8'(i), 1, 0, 2'b00, 0);
        end

        // 4: simultaneous write+pop on a full then on an empty channel
        for (int i = 1; i <= 4; i++) cyc(1, 0, 8'(i), 0, 0, 2'b00, 0);
        cyc(1, 0, 8'h55, 1, 0, 2'b00, 0);
        chk("t4_full_count", 32'(rd_count), 3);
        chk("t4_overflow", 32'(overflow[0]), 1);
        chk("t4_full_head", 32'(data_out), 32'h02);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 1, 0, 2'b00, 0);
        cyc(1, 0, 8'h66, 1, 0, 2'b00, 0);
        chk("t4_empty_count", 32'(rd_count), 1);
        chk("t4_empty_head", 32'(data_out), 32'h66);
        chk("t4_underflow", 32'(underflow[0]), 1);
        cyc(0, 0, 8'h00, 0, 0, 2'b00, 1);

        // 5: flush beats a same-cycle write; other channel untouched
        cyc(1, 0, 8'h67, 0, 0, 2'b00, 0);
        cyc(1, 0, 8'h68, 0, 0, 2'b00, 0);
        cyc(1, 0, 8'h77, 0, 0, 2'b01, 0);
        chk("t5_flush_count", 32'(rd_count), 0);
        chk("t5_flags", 32'({overflow, underflow}), 0);
        look(1);
        chk("t5_ch1_head", 32'(data_out), 32'hC2);
        chk("t5_ch1_count", 32'(rd_count), 4);

        // 6: asynchronous reset between edges
        cyc(1, 0, 8'h99, 0, 1, 2'b00, 0);
        #1 reset = 1'b1;
        #1;
        chk("t6_nonempty", 32'(nonempty), 0);
        chk("t6_full", 32'(full), 0);
        chk("t6_rd_count", 32'(rd_count), 0);
        chk("t6_data_out", 32'(data_out), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        cyc(1, 1, 8'h42, 0, 1, 2'b00, 0);
        chk("t6_resume_head", 32'(data_out), 32'h42);
        chk("t6_resume_count", 32'(rd_count), 1);
        chk("t6_resume_nonempty", 32'(nonempty), 32'h2);

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
